// File: rtl/l2_req_arbiter.sv
// ---------------------------------------------------------------------------
// l2_req_arbiter
//
// Merges I-cache and D-cache miss/uncached traffic onto the single L2 port
// (lowX_req_t / lowX_res_t). Only one transaction is outstanding at a time.
// Between the two requesters, grants alternate round-robin. The accepted
// request is registered before it is issued. The L2 response is steered back
// to the requester that owns the transaction. A watchdog pulses timeout_o
// once if an issued transaction does not complete within TIMEOUT_CYCLES.
//
// Ports:
//   clk_i      clock
//   rst_ni     asynchronous active-low reset
//   ic_req_i   I-cache request (port 0)
//   ic_res_o   response / ready back to the I-cache
//   dc_req_i   D-cache request (port 1)
//   dc_res_o   response / ready back to the D-cache
//   l2_req_o   request to L2 (l1_req_i of l2_cache_multibank)
//   l2_res_i   response from L2 (l1_res_o of l2_cache_multibank)
//   busy_o     a transaction is in flight (FSM not in IDLE)
//   timeout_o  one-cycle pulse on watchdog expiry
// ---------------------------------------------------------------------------
package l2_req_arbiter_pkg;

    typedef struct packed {
        logic        valid;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } lowX_req_t;

    typedef struct packed {
        logic        valid;
        logic        ready;
        logic [31:0] rdata;
    } lowX_res_t;

endpackage

module l2_req_arbiter
    import l2_req_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_W          = 16
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  lowX_req_t ic_req_i,
    output lowX_res_t ic_res_o,
    input  lowX_req_t dc_req_i,
    output lowX_res_t dc_res_o,
    output lowX_req_t l2_req_o,
    input  lowX_res_t l2_res_i,
    output logic      busy_o,
    output logic      timeout_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_e;

    localparam bit               WD_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e           state_q, state_d;
    lowX_req_t        req_q;
    logic             owner_q;     // 0: I-cache, 1: D-cache
    logic             rr_ptr_q;    // port preferred when both request
    logic [CNT_W-1:0] cnt_q;
    logic             fired_q;     // watchdog already pulsed this transaction

    logic             accept;
    logic             winner;
    lowX_res_t        fwd_res;

    // ---------------- next state / outputs ----------------
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        winner    = 1'b0;
        ic_res_o  = '0;
        dc_res_o  = '0;
        l2_req_o  = '0;
        fwd_res   = '0;
        timeout_o = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // No grant while reset is held: the accept could not be
                // registered, and every output must read as zero.
                if (rst_ni && (ic_req_i.valid || dc_req_i.valid)) begin
                    accept = 1'b1;
                    if (ic_req_i.valid && dc_req_i.valid) begin
                        winner = rr_ptr_q;
                    end else begin
                        winner = dc_req_i.valid;
                    end
                    ic_res_o.ready = ~winner;
                    dc_res_o.ready = winner;
                    state_d        = S_ISSUE;
                end
            end

            S_ISSUE: begin
                l2_req_o       = req_q;
                l2_req_o.valid = 1'b1;
                if (l2_res_i.ready) begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (l2_res_i.valid) begin
                    fwd_res       = l2_res_i;
                    fwd_res.valid = 1'b1;
                    fwd_res.ready = 1'b0;
                    if (owner_q) begin
                        dc_res_o = fwd_res;
                    end else begin
                        ic_res_o = fwd_res;
                    end
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase

        if (WD_EN && (state_q != S_IDLE) && !fired_q && (cnt_q == TO_LAST)) begin
            timeout_o = 1'b1;
        end
    end

    assign busy_o = (state_q != S_IDLE);

    // ---------------- state register ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            req_q    <= '0;
            owner_q  <= 1'b0;
            rr_ptr_q <= 1'b0;
            cnt_q    <= '0;
            fired_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                req_q    <= winner ? dc_req_i : ic_req_i;
                owner_q  <= winner;
                rr_ptr_q <= ~winner;
                cnt_q    <= '0;
                fired_q  <= 1'b0;
            end else begin
                if ((state_q != S_IDLE) && (cnt_q != '1)) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                if (timeout_o) begin
                    fired_q <= 1'b1;
                end
            end
        end
    end

endmodule
